// File: rtl/spi_pkg.sv
// spi_pkg: shared encodings, frame lengths and lane helper for the SPI initiator
package spi_pkg;
  typedef enum logic [1:0] {SPI_SINGLE = 2'b00, SPI_DUAL = 2'b01, SPI_QUAD = 2'b10, SPI_RSVD = 2'b11} mode_t;
  typedef enum logic [2:0] {IDLE, SETUP, CMD, WAIT, DATA_RX, DATA_TX, STATUS, HOLD} state_t;
  localparam int HDR_WRITE_BIT = 23;
  localparam int CMD_BITS = 24;
  localparam int DATA_BITS = 16;
  localparam int STATUS_BITS = 8;
  // mode encoding doubles as log2 of the lane count; MSB of the beat goes to the highest used lane
  function automatic logic [3:0] lanes(input logic [3:0] top, input mode_t mode);
    return mode == SPI_QUAD ? top : mode == SPI_DUAL ? {2'b0, top[3:2]} : {3'b0, top[3]};
  endfunction
endpackage

// File: rtl/spi_master_sclk_gen.sv
// spi_sclk_gen: CPOL=0 clock divider with rise/fall ticks marking the edge where sclk toggles
module spi_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);
  logic [7:0] cnt;
  logic tick;
  assign tick = en && cnt == 8'(CLK_DIV - 1);
  assign rise_tick = tick && !sclk;
  assign fall_tick = tick && sclk;
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      cnt <= '0;
      sclk <= !sclk;
    end else cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/spi_master.sv
// spi_master: register-command SPI initiator (single/dual/quad) with status capture
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int WAIT_CYCLES = 2,
  parameter int CS_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_write,
  input  logic [19:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  spi_mode,
  input  logic [3:0]  miso,
  output logic        sclk,
  output logic        cs_n,
  output logic [3:0]  mosi,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err
);
  localparam int HOLD_N = CS_HOLD * CLK_DIV < 1 ? 1 : CS_HOLD * CLK_DIV;
  state_t state, nxt;
  mode_t mode;
  logic wr, en, rise_tick, fall_tick, last;
  logic [39:0] sr, sr_sh;
  logic [23:0] rx, rx_sh;
  logic [15:0] cnt, plen;
  assign en = state inside {CMD, WAIT, DATA_RX, DATA_TX, STATUS};
  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk(clk), .reset(reset), .en(en), .sclk(sclk), .rise_tick(rise_tick), .fall_tick(fall_tick)
  );
  always_comb begin
    plen = state == CMD ? 16'(CMD_BITS >> mode)
         : (state == DATA_RX || state == DATA_TX) ? 16'(DATA_BITS >> mode)
         : state == WAIT ? 16'(WAIT_CYCLES) : 16'(STATUS_BITS >> mode);
    last = cnt == plen - 16'd1;
    sr_sh = mode == SPI_QUAD ? sr << 4 : mode == SPI_DUAL ? sr << 2 : sr << 1;
    rx_sh = mode == SPI_QUAD ? {rx[19:0], miso} : mode == SPI_DUAL ? {rx[21:0], miso[1:0]} : {rx[22:0], miso[0]};
    case (state)
      CMD:     nxt = wr ? DATA_TX : (WAIT_CYCLES > 0 ? WAIT : DATA_RX);
      DATA_TX: nxt = WAIT_CYCLES > 0 ? WAIT : STATUS;
      WAIT:    nxt = wr ? STATUS : DATA_RX;
      DATA_RX: nxt = STATUS;
      default: nxt = HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cs_n <= 1'b1;
      mosi <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rdata <= '0;
      err <= 1'b0;
      mode <= SPI_SINGLE;
      wr <= 1'b0;
      sr <= '0;
      rx <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // done gates acceptance so a start in the completion cycle waits one more cycle
        IDLE: if (start && !done) begin
          if (spi_mode == SPI_RSVD) begin
            done <= 1'b1;
            err <= 1'b1;
          end else begin
            state <= SETUP;
            busy <= 1'b1;
            wr <= cmd_write;
            mode <= mode_t'(spi_mode);
            sr <= {cmd_write, 3'b000, cmd_addr, cmd_wdata};
            rx <= '0;
            rdata <= '0;
            err <= 1'b0;
            cnt <= '0;
          end
        end
        SETUP: begin
          state <= CMD;
          cs_n <= 1'b0;
          mosi <= lanes(sr[39:36], mode);
        end
        HOLD: if (cnt == 16'(HOLD_N - 1)) begin
          state <= IDLE;
          cs_n <= 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
          err <= rx[0];
          if (!wr) rdata <= rx[23:8];
        end else cnt <= cnt + 16'd1;
        default: begin
          if (rise_tick && (state == DATA_RX || state == STATUS)) rx <= rx_sh;
          if (fall_tick) begin
            sr <= sr_sh;
            cnt <= last ? '0 : cnt + 16'd1;
            if (last) state <= nxt;
            mosi <= ((state == CMD && !(last && !wr)) || (state == DATA_TX && !last)) ? lanes(sr_sh[39:36], mode) : 4'b0;
          end
        end
      endcase
    end
  end
endmodule
